sop_pos_engine: RTL and testbench
=================================

Name: sop_pos_engine

Overview:
- Parametrised, sequential successor to the fixed 3-input SOP/POS gate networks.
- Holds a programmable 2^N-entry truth table. On request, evaluates one input vector two ways: as a sum of minterms (f_sop) and as a product of maxterms (f_pos).
- Scans one table index per clock.
- Used as a reusable Boolean-function evaluator and as a self-checking SOP/POS equivalence unit in lab datapaths.

Parameters:
- N, 3, number of function inputs; legal range 1..8. Table depth is 2^N.

Ports:
- clock  input  1  system clock; all state changes on its rising edge
- reset_L  input  1  asynchronous, active-low reset
- tt_load  input  1  load tt_in into the truth-table register
- tt_in  input  2^N  truth table; bit i is the function value for input vector i
- start  input  1  request evaluation of vars
- vars  input  N  input vector; MSB is the first variable (A), LSB the last
- busy  output  1  high while scanning
- done  output  1  one-cycle pulse when results update
- f_sop  output  1  OR over i of (vars==i & tt[i])
- f_pos  output  1  AND over i of (vars!=i | tt[i])
- mismatch  output  1  f_sop != f_pos on the last completed evaluation

Behaviour:
- Reset is asynchronous and active-low. While reset_L=0:
  - state=IDLE, table=0, idx=0, latched vars=0
  - busy=0, done=0, f_sop=0, f_pos=0, mismatch=0
- Reset asserted mid-scan aborts the scan immediately. No done pulse; results revert to reset values.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - tt_load=1 captures tt_in at the edge.
  - start=1 at edge k: latch vars, set idx=0, acc_sop=0, acc_pos=1, go to SCAN.
  - tt_load and start at the same edge: the table loads and the scan uses the new table.
- SCAN:
  - busy=1.
  - Each edge processes idx: acc_sop |= (vl==idx)&tt[idx]; acc_pos &= (vl!=idx)|tt[idx]; idx++.
  - At the edge processing idx=2^N-1:
    - f_sop and f_pos take the final accumulator values, including that last term.
    - mismatch <= final acc_sop ^ final acc_pos.
    - Go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency: done is high in the cycle after edge k+2^N, i.e. 2^N cycles after the start edge.
- start and tt_load are ignored in SCAN and DONE. There is no queuing; the table is frozen during evaluation.
- Changes to vars after the start edge have no effect.
- f_sop, f_pos and mismatch hold their values until the next evaluation completes.
- Index counter is N+1 bits wide, so there is no wrap-around ambiguity at 2^N-1. It is cleared on every start.
- Back-to-back requests: start high in the cycle after done is accepted.

Optional Feature:
- Macro: SOP_POS_EARLY_EXIT_EN.
- When defined:
  - SCAN ends at the edge that processes idx==vl.
  - Results equal the full scan, since all other terms are neutral.
  - Latency is vl+1 cycles after the start edge; done is high in the cycle after edge k+vl+1.
  - vars=0 gives the minimum latency of 1.
- When undefined: fixed 2^N-cycle scan as above.

Test Plan:
1. N=3, load tt=8'h25 (F=A'C'+AB'C), start vars=3'b010 -> done 8 cycles later; f_sop=1, f_pos=1, mismatch=0, busy high exactly 8 cycles.
2. Same table, vars=3'b011 -> f_sop=0, f_pos=0. Then vars=3'b101 -> both 1.
3. Load tt=8'h96 (G), sweep vars 0..7 back-to-back with start the cycle after each done -> outputs 0,1,1,0,1,0,0,1; no lost requests.
4. Start vars=3'b010; assert tt_load with 8'h00 and a second start during SCAN -> both ignored; result 1; exactly one done pulse.
5. Start, then drop reset_L at scan cycle 4 -> all outputs 0 immediately, no done. After release, evaluation behaves normally and the table reads as 0.
6. With SOP_POS_EARLY_EXIT_EN, tt=8'h96: vars=0 -> done after 1 cycle, f=0; vars=7 -> done after 8 cycles, f=1.

Source files
------------

// File: rtl/sop_pos_engine_if.sv
// Bus bundle for sop_pos_engine: table load, evaluation request and results.
// master drives the request side, slave is the engine.
interface sop_pos_engine_if #(
   parameter int N = 3
);
   logic                tt_load;
   logic [(1<<N)-1:0]   tt_in;
   logic                start;
   logic [N-1:0]        vars;
   logic                busy;
   logic                done;
   logic                f_sop;
   logic                f_pos;
   logic                mismatch;

   modport master (
      output tt_load, tt_in, start, vars,
      input  busy, done, f_sop, f_pos, mismatch
   );

   modport slave (
      input  tt_load, tt_in, start, vars,
      output busy, done, f_sop, f_pos, mismatch
   );
endinterface

// File: rtl/sop_pos_engine.sv
// sop_pos_engine: programmable 2^N-entry truth table evaluated one index per
// clock, both as a sum of minterms (f_sop) and a product of maxterms (f_pos).
// Optional macro SOP_POS_EARLY_EXIT_EN ends the scan at the index matching
// the latched input vector; remaining terms are neutral, so results match.
module sop_pos_engine #(
   parameter int N = 3
) (
   input  logic              clock,
   input  logic              reset_L,
   sop_pos_engine_if.slave   bus
);

   localparam int unsigned DEPTH    = 1 << N;
   localparam logic [N:0]  IDX_LAST = (N+1)'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t            state_q;
   logic [DEPTH-1:0]  tt_q;
   logic [N:0]        idx_q;
   logic [N-1:0]      vl_q;
   logic              acc_sop_q;
   logic              acc_pos_q;
   logic              busy_q;
   logic              done_q;
   logic              f_sop_q;
   logic              f_pos_q;
   logic              mismatch_q;

   logic              hit;
   logic              tt_bit;
   logic              acc_sop_d;
   logic              acc_pos_d;
   logic              last_d;

   // Fold the term at the current index into both accumulators.
   always_comb begin
      hit       = (idx_q == {1'b0, vl_q});
      tt_bit    = tt_q[idx_q[N-1:0]];
      acc_sop_d = acc_sop_q | (hit & tt_bit);
      acc_pos_d = acc_pos_q & (~hit | tt_bit);
`ifdef SOP_POS_EARLY_EXIT_EN
      last_d    = hit;
`else
      last_d    = (idx_q == IDX_LAST);
`endif
   end

   // Control FSM with registered status and result outputs.
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state_q    <= IDLE;
         tt_q       <= '0;
         idx_q      <= '0;
         vl_q       <= '0;
         acc_sop_q  <= 1'b0;
         acc_pos_q  <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         f_sop_q    <= 1'b0;
         f_pos_q    <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.tt_load) tt_q <= bus.tt_in;
               if (bus.start) begin
                  vl_q      <= bus.vars;
                  idx_q     <= '0;
                  acc_sop_q <= 1'b0;
                  acc_pos_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= SCAN;
               end
            end
            SCAN: begin
               acc_sop_q <= acc_sop_d;
               acc_pos_q <= acc_pos_d;
               idx_q     <= idx_q + 1'b1;
               if (last_d) begin
                  f_sop_q    <= acc_sop_d;
                  f_pos_q    <= acc_pos_d;
                  mismatch_q <= acc_sop_d ^ acc_pos_d;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.f_sop    = f_sop_q;
   assign bus.f_pos    = f_pos_q;
   assign bus.mismatch = mismatch_q;

endmodule

// File: tb/tb_sop_pos_engine.sv
// Bench for sop_pos_engine (N=3): vector table plus hand sequences for
// mid-scan request injection and mid-scan reset.
module tb_sop_pos_engine;

   logic clock = 1'b0;
   logic reset_L;

   sop_pos_engine_if #(.N(3)) bus ();

   sop_pos_engine #(.N(3)) dut (
      .clock   (clock),
      .reset_L (reset_L),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       ld;
      logic [7:0] tt;
      logic [2:0] v;
      logic       f;
   } vec_t;

   typedef struct {
      logic f;
      int   lat;
   } exp_t;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];
   vec_t vecs[11];

   function automatic int exp_lat(input logic [2:0] v);
`ifdef SOP_POS_EARLY_EXIT_EN
      return int'(v) + 1;
`else
      return 8;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Called just after a negedge; drives one start cycle and records the expectation.
   task automatic start_eval(input logic ld, input logic [7:0] tt, input logic [2:0] v, input logic f);
      exp_t e;
      bus.tt_load = ld;
      bus.tt_in   = tt;
      bus.start   = 1'b1;
      bus.vars    = v;
      e.f   = f;
      e.lat = exp_lat(v);
      sb.push_back(e);
      @(negedge clock);
      bus.start   = 1'b0;
      bus.tt_load = 1'b0;
      bus.vars    = ~v;
      bus.tt_in   = ~tt;
   endtask

   // Entered at the first negedge after the start edge; returns at the done cycle.
   task automatic finish_eval(input string tag);
      int   cyc = 1;
      int   bc  = 0;
      exp_t e;
      while (bus.done !== 1'b1 && cyc < 64) begin
         if (bus.busy === 1'b1) bc++;
         @(negedge clock);
         cyc++;
      end
      if (sb.size() == 0) begin
         chk({tag, "_scoreboard"}, 0, 1);
         return;
      end
      e = sb.pop_front();
      if (bus.done !== 1'b1) begin
         chk({tag, "_timeout"}, 0, 1);
         return;
      end
      chk({tag, "_latency"},  cyc - 1,      e.lat);
      chk({tag, "_busy_cyc"}, bc,           e.lat);
      chk({tag, "_busy_at_done"}, bus.busy, 0);
      chk({tag, "_f_sop"},    bus.f_sop,    e.f);
      chk({tag, "_f_pos"},    bus.f_pos,    e.f);
      chk({tag, "_mismatch"}, bus.mismatch, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dcount;

      vecs = '{
         '{1'b1, 8'h25, 3'd2, 1'b1},
         '{1'b0, 8'h25, 3'd3, 1'b0},
         '{1'b0, 8'h25, 3'd5, 1'b1},
         '{1'b1, 8'h96, 3'd0, 1'b0},
         '{1'b0, 8'h96, 3'd1, 1'b1},
         '{1'b0, 8'h96, 3'd2, 1'b1},
         '{1'b0, 8'h96, 3'd3, 1'b0},
         '{1'b0, 8'h96, 3'd4, 1'b1},
         '{1'b0, 8'h96, 3'd5, 1'b0},
         '{1'b0, 8'h96, 3'd6, 1'b0},
         '{1'b0, 8'h96, 3'd7, 1'b1}
      };

      reset_L     = 1'b0;
      bus.tt_load = 1'b0;
      bus.tt_in   = '0;
      bus.start   = 1'b0;
      bus.vars    = '0;
      repeat (2) @(negedge clock);
      chk("rst_busy",     bus.busy,     0);
      chk("rst_done",     bus.done,     0);
      chk("rst_f_sop",    bus.f_sop,    0);
      chk("rst_f_pos",    bus.f_pos,    0);
      chk("rst_mismatch", bus.mismatch, 0);
      reset_L = 1'b1;

      // Table vectors; the 0x96 sweep runs back-to-back, start in the cycle after done.
      for (int i = 0; i < 11; i++) begin
         @(negedge clock);
         if (i > 0) chk($sformatf("vec%0d_done_width", i), bus.done, 0);
         start_eval(vecs[i].ld, vecs[i].tt, vecs[i].v, vecs[i].f);
         finish_eval($sformatf("vec%0d", i));
      end

      // Load and second start during SCAN must be ignored.
      @(negedge clock);
      start_eval(1'b1, 8'h25, 3'd2, 1'b1);
      fork
         begin
            bus.tt_load = 1'b1;
            bus.tt_in   = 8'h00;
            bus.start   = 1'b1;
            bus.vars    = 3'd3;
            @(negedge clock);
            bus.tt_load = 1'b0;
            bus.start   = 1'b0;
         end
      join_none
      finish_eval("inject");
      dcount = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clock);
         if (bus.done === 1'b1) dcount++;
      end
      chk("inject_extra_done", dcount, 0);
      start_eval(1'b0, 8'h00, 3'd5, 1'b1);
      finish_eval("inject_table_kept");

      // Reset mid-scan aborts immediately and clears the table.
      @(negedge clock);
      start_eval(1'b1, 8'h96, 3'd7, 1'b1);
      repeat (3) @(negedge clock);
      #2 reset_L = 1'b0;
      #1;
      chk("abort_busy",     bus.busy,     0);
      chk("abort_done",     bus.done,     0);
      chk("abort_f_sop",    bus.f_sop,    0);
      chk("abort_f_pos",    bus.f_pos,    0);
      chk("abort_mismatch", bus.mismatch, 0);
      void'(sb.pop_front());
      repeat (2) @(negedge clock);
      reset_L = 1'b1;
      dcount = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         if (bus.done === 1'b1) dcount++;
      end
      chk("abort_no_done", dcount, 0);
      start_eval(1'b0, 8'h00, 3'd7, 1'b0);
      finish_eval("post_rst_zero_table");
      @(negedge clock);
      start_eval(1'b1, 8'h96, 3'd7, 1'b1);
      finish_eval("post_rst_reload");

      @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
